// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
//
// Sequencer for a pair of external N_BITS-wide shift registers (A and B).
// One press of Execute runs exactly one operation: N_BITS consecutive
// Shift_En cycles. On each of those cycles the serial LSBs of A and B are
// combined by a bitwise function and routed back into the registers' MSB
// fill inputs. Function and routing selects are captured when the operation
// starts, so they cannot change while the operation is running.
//
// Parameters
//   N_BITS      shift cycles per operation (attached register width)
//
// Ports
//   Clk         clock; all state updates on the rising edge
//   Reset_n     asynchronous active-low reset
//   Execute     level start request (already synchronous and debounced)
//   LoadA/LoadB parallel-load requests, passed through only in IDLE
//   F[2:0]      bitwise function select (captured at start)
//   R[1:0]      result routing select (captured at start)
//   A_Out/B_Out serial LSBs of registers A and B
//   Ld_A/Ld_B   load strobes to registers A and B
//   Shift_En    shift enable to both registers
//   A_Shift_In  MSB fill of register A
//   B_Shift_In  MSB fill of register B
//   Busy        high while shifting
//   Done        high after an operation until Execute is released
// -----------------------------------------------------------------------------
module shift_seq_ctrl #(
  parameter int N_BITS = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Execute,
  input  logic       LoadA,
  input  logic       LoadB,
  input  logic [2:0] F,
  input  logic [1:0] R,
  input  logic       A_Out,
  input  logic       B_Out,
  output logic       Ld_A,
  output logic       Ld_B,
  output logic       Shift_En,
  output logic       A_Shift_In,
  output logic       B_Shift_In,
  output logic       Busy,
  output logic       Done
);

  // A 1-bit counter is kept for N_BITS == 1 so the vector is never zero-width.
  localparam int CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    HOLD  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       f_q, f_d;
  logic [1:0]       r_q, r_d;

  logic             fb;
  logic             in_shift;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      r_q     <= r_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    r_d     = r_q;

    case (state_q)
      IDLE: begin
        if (Execute) begin
          // Selects are frozen here for the whole operation.
          state_d = SHIFT;
          cnt_d   = '0;
          f_d     = F;
          r_d     = R;
        end
      end

      SHIFT: begin
        cnt_d = cnt_q + CNT_ONE;
        // The cycle with cnt_q == N_BITS-1 is the last shift cycle.
        if (cnt_q == CNT_LAST) begin
          state_d = HOLD;
        end
      end

      HOLD: begin
        // Wait for Execute to drop so a held button runs only once.
        if (!Execute) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Function bit: combinational on the current LSBs so each shift cycle
  // consumes the bits presented that cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    fb = 1'b0;
    case (f_q)
      3'b000:  fb =   A_Out & B_Out;
      3'b001:  fb =   A_Out | B_Out;
      3'b010:  fb =   A_Out ^ B_Out;
      3'b011:  fb =   1'b1;
      3'b100:  fb = ~(A_Out & B_Out);
      3'b101:  fb = ~(A_Out | B_Out);
      3'b110:  fb = ~(A_Out ^ B_Out);
      default: fb =   1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Routing. Outside SHIFT both registers recirculate their own LSB, which
  // keeps their contents intact even if something else shifts them.
  // ---------------------------------------------------------------------------
  assign in_shift = (state_q == SHIFT);

  always_comb begin
    A_Shift_In = A_Out;
    B_Shift_In = B_Out;
    if (in_shift) begin
      case (r_q)
        2'b01: A_Shift_In = fb;
        2'b10: B_Shift_In = fb;
        2'b11: begin
          A_Shift_In = B_Out;
          B_Shift_In = A_Out;
        end
        default: begin
          A_Shift_In = A_Out;
          B_Shift_In = B_Out;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Status and control outputs. Load strobes are gated by Reset_n as well,
  // so they drop immediately while reset is held, not only once the state
  // register has cleared.
  // ---------------------------------------------------------------------------
  assign Shift_En = in_shift;
  assign Busy     = in_shift;
  assign Done     = (state_q == HOLD);
  assign Ld_A     = Reset_n && (state_q == IDLE) && LoadA;
  assign Ld_B     = Reset_n && (state_q == IDLE) && LoadB;

endmodule
